// File: rtl/data_mem_access_unit_if.sv
// Data-memory port bundle: request/ack handshake with address, store data and load data.
interface data_mem_access_unit_if;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        input  mem_rdata,
        input  mem_ack
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        output mem_rdata,
        output mem_ack
    );
endinterface

// File: rtl/data_mem_access_unit.sv
// Memory-stage load/store engine: one req/ack transaction per accepted op, load writeback
// pulse, upstream stall while busy, and an optional no-ack timeout.
module data_mem_access_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           valid_in,
    input  logic [6:0]                     opcode_in,
    input  logic [31:0]                    addr_in,
    input  logic [31:0]                    str_data_in,
    input  logic [3:0]                     rd_in,
    output logic                           stall_out,
    data_mem_access_unit_if.master         mem,
    output logic                           w_en_ldr_out,
    output logic [31:0]                    ldr_data_out,
    output logic [3:0]                     ldr_rd_out,
    output logic                           err_out
);

    localparam int unsigned CNT_W  = (TIMEOUT_CYCLES == 0) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam int unsigned LAST_I = (TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAST_I);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        WB
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             is_load;
    logic             is_store;
    logic             timeout_hit;

    always_comb begin
        is_load     = (opcode_in[6:4] == 3'b110) || (opcode_in[6:3] == 4'b1000);
        is_store    = (opcode_in[6:4] == 3'b111) || (opcode_in[6:3] == 4'b1001);
        timeout_hit = (TIMEOUT_CYCLES != 0) && (cnt == CNT_LAST);
        stall_out   = (state != IDLE);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state         <= IDLE;
            cnt           <= '0;
            mem.mem_req   <= 1'b0;
            mem.mem_we    <= 1'b0;
            mem.mem_addr  <= '0;
            mem.mem_wdata <= '0;
            w_en_ldr_out  <= 1'b0;
            ldr_data_out  <= '0;
            ldr_rd_out    <= '0;
            err_out       <= 1'b0;
        end else begin
            // Writeback enable and error are single-cycle pulses.
            w_en_ldr_out <= 1'b0;
            err_out      <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (valid_in && (is_load || is_store)) begin
                        mem.mem_addr  <= addr_in;
                        mem.mem_wdata <= str_data_in;
                        mem.mem_we    <= is_store;
                        ldr_rd_out    <= rd_in;
                        cnt           <= '0;
                        mem.mem_req   <= 1'b1;
                        state         <= ACCESS;
                    end
                end
                ACCESS: begin
                    // Ack is checked before the timeout so a last-cycle ack still completes.
                    if (mem.mem_ack) begin
                        mem.mem_req <= 1'b0;
                        if (!mem.mem_we) begin
                            ldr_data_out <= mem.mem_rdata;
                            w_en_ldr_out <= 1'b1;
                            state        <= WB;
                        end else begin
                            state <= IDLE;
                        end
                    end else if (timeout_hit) begin
                        mem.mem_req <= 1'b0;
                        err_out     <= 1'b1;
                        state       <= IDLE;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + CNT_ONE;
                    end
                end
                WB: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Directed bench for data_mem_access_unit: per-cycle vector table plus a hand-written delayed-ack load.
module tb_data_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid_in;
    logic [6:0]  opcode_in;
    logic [31:0] addr_in;
    logic [31:0] str_data_in;
    logic [3:0]  rd_in;
    logic        stall_out;
    logic        w_en_ldr_out;
    logic [31:0] ldr_data_out;
    logic [3:0]  ldr_rd_out;
    logic        err_out;

    data_mem_access_unit_if mem_bus ();

    data_mem_access_unit #(.TIMEOUT_CYCLES(4)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .valid_in     (valid_in),
        .opcode_in    (opcode_in),
        .addr_in      (addr_in),
        .str_data_in  (str_data_in),
        .rd_in        (rd_in),
        .stall_out    (stall_out),
        .mem          (mem_bus.master),
        .w_en_ldr_out (w_en_ldr_out),
        .ldr_data_out (ldr_data_out),
        .ldr_rd_out   (ldr_rd_out),
        .err_out      (err_out)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rst_n;
        logic        valid;
        logic [6:0]  op;
        logic [31:0] addr;
        logic [31:0] wd;
        logic [3:0]  rd;
        logic        ack;
        logic [31:0] rdata;
    } vin_t;

    typedef struct packed {
        logic        stall;
        logic        req;
        logic        we;
        logic [31:0] maddr;
        logic [31:0] mwd;
        logic        wen;
        logic [31:0] ldata;
        logic [3:0]  lrd;
        logic        err;
    } vout_t;

    typedef struct {
        vin_t  i;
        vout_t o;
    } vec_t;

    localparam logic [31:0] LD = 32'h60;
    localparam logic [31:0] ST = 32'h70;
    localparam logic [31:0] NM = 32'h04;

    vec_t vt[$];
    int   compared   = 0;
    int   mismatched = 0;

    function automatic void add(
        input logic [31:0] rs, input logic [31:0] v, input logic [31:0] op, input logic [31:0] a,
        input logic [31:0] wd, input logic [31:0] rd, input logic [31:0] ack, input logic [31:0] rdat,
        input logic [31:0] st, input logic [31:0] rq, input logic [31:0] we, input logic [31:0] ma,
        input logic [31:0] mw, input logic [31:0] wen, input logic [31:0] ld, input logic [31:0] lr,
        input logic [31:0] er);
        vec_t e;
        e.i.rst_n = rs[0];  e.i.valid = v[0];  e.i.op = op[6:0];  e.i.addr = a;
        e.i.wd = wd;  e.i.rd = rd[3:0];  e.i.ack = ack[0];  e.i.rdata = rdat;
        e.o.stall = st[0];  e.o.req = rq[0];  e.o.we = we[0];  e.o.maddr = ma;  e.o.mwd = mw;
        e.o.wen = wen[0];  e.o.ldata = ld;  e.o.lrd = lr[3:0];  e.o.err = er[0];
        vt.push_back(e);
    endfunction

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        compared++;
        if (got !== exp) begin
            mismatched++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    initial begin
        vout_t       got;
        int          n_stall, n_req, n_wen, n_err;
        logic [31:0] wb_data;
        logic [3:0]  wb_rd;

        rst_n = 1'b0; valid_in = 1'b0; opcode_in = '0; addr_in = '0; str_data_in = '0; rd_in = '0;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;

        //  rst v  op       addr     wdata         rd ack rdata          stall req we maddr   mwd           wen ldata          lrd err
        add(0, 0, NM,      0,       0,            0, 0, 0,             0, 0, 0, 0,      0,            0, 0,            0, 0);
        add(0, 0, NM,      0,       0,            0, 0, 0,             0, 0, 0, 0,      0,            0, 0,            0, 0);
        // load r5 from 0x100, immediate ack
        add(1, 1, LD,      'h100,   'h11111111,   5, 0, 0,             1, 1, 0, 'h100,  'h11111111,   0, 0,            5, 0);
        add(1, 0, LD,      0,       0,            0, 1, 'hDEADBEEF,    1, 0, 0, 'h100,  'h11111111,   1, 'hDEADBEEF,   5, 0);
        add(1, 0, LD,      0,       0,            0, 0, 0,             0, 0, 0, 'h100,  'h11111111,   0, 'hDEADBEEF,   5, 0);
        // store to 0x200 with ack in 4th cycle; op offered mid-access must be ignored
        add(1, 1, ST,      'h200,   'hCAFEF00D,   9, 0, 0,             1, 1, 1, 'h200,  'hCAFEF00D,   0, 'hDEADBEEF,   9, 0);
        add(1, 1, LD,      'h999,   0,            2, 0, 0,             1, 1, 1, 'h200,  'hCAFEF00D,   0, 'hDEADBEEF,   9, 0);
        add(1, 0, 0,       0,       0,            0, 0, 0,             1, 1, 1, 'h200,  'hCAFEF00D,   0, 'hDEADBEEF,   9, 0);
        add(1, 0, 0,       0,       0,            0, 0, 0,             1, 1, 1, 'h200,  'hCAFEF00D,   0, 'hDEADBEEF,   9, 0);
        add(1, 0, 0,       0,       0,            0, 1, 'h5,           0, 0, 1, 'h200,  'hCAFEF00D,   0, 'hDEADBEEF,   9, 0);
        // non-memory opcode, stray ack in IDLE, and invalid load
        add(1, 1, NM,      'h300,   5,            3, 1, 'h77,          0, 0, 1, 'h200,  'hCAFEF00D,   0, 'hDEADBEEF,   9, 0);
        add(1, 0, LD,      'h300,   5,            3, 0, 0,             0, 0, 1, 'h200,  'hCAFEF00D,   0, 'hDEADBEEF,   9, 0);
        // timeout (TIMEOUT_CYCLES=4), alternate load encoding 1000xxx
        add(1, 1, 'h45,    'h400,   0,            7, 0, 0,             1, 1, 0, 'h400,  0,            0, 'hDEADBEEF,   7, 0);
        add(1, 0, 0,       0,       0,            0, 0, 0,             1, 1, 0, 'h400,  0,            0, 'hDEADBEEF,   7, 0);
        add(1, 0, 0,       0,       0,            0, 0, 0,             1, 1, 0, 'h400,  0,            0, 'hDEADBEEF,   7, 0);
        add(1, 0, 0,       0,       0,            0, 0, 0,             1, 1, 0, 'h400,  0,            0, 'hDEADBEEF,   7, 0);
        add(1, 0, 0,       0,       0,            0, 0, 0,             0, 0, 0, 'h400,  0,            0, 'hDEADBEEF,   7, 1);
        add(1, 0, 0,       0,       0,            0, 0, 0,             0, 0, 0, 'h400,  0,            0, 'hDEADBEEF,   7, 0);
        add(1, 1, 'h6F,    'h500,   0,            2, 0, 0,             1, 1, 0, 'h500,  0,            0, 'hDEADBEEF,   2, 0);
        add(1, 0, 0,       0,       0,            0, 1, 'h12345678,    1, 0, 0, 'h500,  0,            1, 'h12345678,   2, 0);
        add(1, 0, 0,       0,       0,            0, 0, 0,             0, 0, 0, 'h500,  0,            0, 'h12345678,   2, 0);
        // ack arriving in the 4th (last) access cycle wins over timeout
        add(1, 1, 'h61,    'h600,   'hA5A5A5A5,   1, 0, 0,             1, 1, 0, 'h600,  'hA5A5A5A5,   0, 'h12345678,   1, 0);
        add(1, 0, 0,       0,       0,            0, 0, 0,             1, 1, 0, 'h600,  'hA5A5A5A5,   0, 'h12345678,   1, 0);
        add(1, 0, 0,       0,       0,            0, 0, 0,             1, 1, 0, 'h600,  'hA5A5A5A5,   0, 'h12345678,   1, 0);
        add(1, 0, 0,       0,       0,            0, 0, 0,             1, 1, 0, 'h600,  'hA5A5A5A5,   0, 'h12345678,   1, 0);
        add(1, 0, 0,       0,       0,            0, 1, 'h0BADF00D,    1, 0, 0, 'h600,  'hA5A5A5A5,   1, 'h0BADF00D,   1, 0);
        add(1, 0, 0,       0,       0,            0, 0, 0,             0, 0, 0, 'h600,  'hA5A5A5A5,   0, 'h0BADF00D,   1, 0);
        // reset mid-access, late ack afterwards
        add(1, 1, ST,      'h700,   'h77777777,   4, 0, 0,             1, 1, 1, 'h700,  'h77777777,   0, 'h0BADF00D,   4, 0);
        add(0, 0, 0,       0,       0,            0, 0, 0,             0, 0, 0, 0,      0,            0, 0,            0, 0);
        add(1, 0, 0,       0,       0,            0, 1, 'hFFFFFFFF,    0, 0, 0, 0,      0,            0, 0,            0, 0);
        add(1, 0, 0,       0,       0,            0, 0, 0,             0, 0, 0, 0,      0,            0, 0,            0, 0);
        // back-to-back load, store, load with upstream holding while stalled
        add(1, 1, LD,      'h10,    0,            3, 0, 0,             1, 1, 0, 'h10,   0,            0, 0,            3, 0);
        add(1, 1, ST,      'h20,    'h44,         6, 1, 'h33,          1, 0, 0, 'h10,   0,            1, 'h33,         3, 0);
        add(1, 1, ST,      'h20,    'h44,         6, 0, 0,             0, 0, 0, 'h10,   0,            0, 'h33,         3, 0);
        add(1, 1, ST,      'h20,    'h44,         6, 0, 0,             1, 1, 1, 'h20,   'h44,         0, 'h33,         6, 0);
        add(1, 1, LD,      'h30,    0,            8, 1, 'h99,          0, 0, 1, 'h20,   'h44,         0, 'h33,         6, 0);
        add(1, 1, LD,      'h30,    0,            8, 0, 0,             1, 1, 0, 'h30,   0,            0, 'h33,         8, 0);
        add(1, 0, 0,       0,       0,            0, 1, 'h55,          1, 0, 0, 'h30,   0,            1, 'h55,         8, 0);
        add(1, 0, 0,       0,       0,            0, 0, 0,             0, 0, 0, 'h30,   0,            0, 'h55,         8, 0);

        foreach (vt[k]) begin
            @(negedge clk);
            rst_n = vt[k].i.rst_n; valid_in = vt[k].i.valid; opcode_in = vt[k].i.op;
            addr_in = vt[k].i.addr; str_data_in = vt[k].i.wd; rd_in = vt[k].i.rd;
            mem_bus.mem_ack = vt[k].i.ack; mem_bus.mem_rdata = vt[k].i.rdata;
            @(posedge clk);
            #1;
            got = '{stall_out, mem_bus.mem_req, mem_bus.mem_we, mem_bus.mem_addr, mem_bus.mem_wdata,
                    w_en_ldr_out, ldr_data_out, ldr_rd_out, err_out};
            compared++;
            if (got !== vt[k].o) begin
                mismatched++;
                $display("FAIL vec%0d got stall=%b req=%b we=%b addr=%h wd=%h wen=%b ld=%h rd=%h err=%b exp stall=%b req=%b we=%b addr=%h wd=%h wen=%b ld=%h rd=%h err=%b",
                         k, got.stall, got.req, got.we, got.maddr, got.mwd, got.wen, got.ldata, got.lrd, got.err,
                         vt[k].o.stall, vt[k].o.req, vt[k].o.we, vt[k].o.maddr, vt[k].o.mwd, vt[k].o.wen,
                         vt[k].o.ldata, vt[k].o.lrd, vt[k].o.err);
            end
        end

        // Load with ack one cycle late: 3 stall cycles, 2 req cycles, one writeback pulse.
        n_stall = 0; n_req = 0; n_wen = 0; n_err = 0; wb_data = '0; wb_rd = '0;
        @(negedge clk);
        valid_in = 1'b1; opcode_in = 7'h60; addr_in = 32'h800; str_data_in = '0; rd_in = 4'hF;
        mem_bus.mem_ack = 1'b0; mem_bus.mem_rdata = '0;
        for (int c = 0; c < 6; c++) begin
            @(posedge clk);
            #1;
            n_stall += int'(stall_out);
            n_req   += int'(mem_bus.mem_req);
            n_err   += int'(err_out);
            if (w_en_ldr_out) begin
                n_wen++;
                wb_data = ldr_data_out;
                wb_rd   = ldr_rd_out;
            end
            @(negedge clk);
            valid_in = 1'b0;
            mem_bus.mem_ack   = (c == 1);
            mem_bus.mem_rdata = (c == 1) ? 32'hC0FFEE00 : 32'h0;
        end
        check("late_ack_stall_cycles", n_stall, 3);
        check("late_ack_req_cycles", n_req, 2);
        check("late_ack_wen_pulses", n_wen, 1);
        check("late_ack_err_pulses", n_err, 0);
        check("late_ack_wb_data", wb_data, 32'hC0FFEE00);
        check("late_ack_wb_rd", {28'd0, wb_rd}, 32'hF);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
